// File: rtl/m_mpu_pkg.sv
// Shared definitions for the MPU serial transmit path: FSM state encoding
// and default geometry for the transmit scheduler.
package m_mpu_pkg;

    localparam int WORD_DFLT      = 8;
    localparam int NOB_DFLT       = 4;
    localparam int MUX_DFLT       = 2;
    localparam int DEF_RATIO_DFLT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/m_tick_gen.sv
// Divide-by-ratio tick generator: one-cycle tick every 'ratio' clocks,
// restarting from zero whenever clear is held.
module m_tick_gen #(
    parameter int NOB = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic [NOB-1:0] ratio,
    output logic           tick
);

    logic [NOB-1:0] r_cnt;
    logic           w_last;

    // ratio is never 0 here; the scheduler clamps it to at least 1
    assign w_last = (r_cnt == ratio - NOB'(1));
    assign tick   = !clear && w_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + NOB'(1);
        end
    end

endmodule

// File: rtl/m_tx_scheduler.sv
// Round-robin scheduler sharing one serial line between NREQ requesters;
// the granted word is shifted out MSB first at ratio_frame clocks per bit.
module m_tx_scheduler
    import m_mpu_pkg::*;
#(
    parameter int WORD      = WORD_DFLT,
    parameter int NOB       = NOB_DFLT,
    parameter int MUX       = MUX_DFLT,
    parameter int DEF_RATIO = DEF_RATIO_DFLT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ratio_setting,
    input  logic [NOB-1:0]         divide_ratio,
    input  logic [(2**MUX)-1:0]    req,
    input  logic [(2**MUX)*WORD-1:0] data_in,
    output logic [(2**MUX)-1:0]    ack,
    output logic [MUX-1:0]         grant_id,
    output logic                   busy,
    output logic                   data_o,
    output logic                   bit_valid,
    output logic                   done
);

    localparam int NREQ = 2**MUX;
    localparam int BCW  = (WORD > 1) ? $clog2(WORD) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD - 1);

    tx_state_e       r_state;
    tx_state_e       w_next_state;
    logic [MUX-1:0]  r_grant_id;
    logic [MUX-1:0]  r_last_grant;
    logic [MUX-1:0]  w_sel;
    logic            w_any_req;
    logic [WORD-1:0] r_shreg;
    logic [NOB-1:0]  r_ratio_reg;
    logic [NOB-1:0]  r_ratio_frame;
    logic [NOB-1:0]  w_ratio_eff;
    logic [BCW-1:0]  r_bit_cnt;
    logic            w_tick;
    logic            w_tick_clear;

    assign w_ratio_eff  = (r_ratio_reg == '0) ? NOB'(1) : r_ratio_reg;
    assign w_tick_clear = (r_state != SHIFT);

    m_tick_gen #(
        .NOB(NOB)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(w_tick_clear),
        .ratio(r_ratio_frame),
        .tick (w_tick)
    );

    // Search starts just after the last served requester, so a requester
    // waits at most NREQ-1 frames.
    always_comb begin : arbiter
        logic [MUX-1:0] idx;
        w_sel     = r_last_grant;
        w_any_req = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = r_last_grant + MUX'(i);
            if (!w_any_req && req[idx]) begin
                w_sel     = idx;
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ack          = '0;
        busy         = 1'b1;
        data_o       = 1'b0;
        bit_valid    = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                ack          = NREQ'(1) << r_grant_id;
                w_next_state = SHIFT;
            end
            SHIFT: begin
                data_o    = r_shreg[WORD-1];
                bit_valid = 1'b1;
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant_id    <= '0;
            r_last_grant  <= MUX'(NREQ - 1);
            r_shreg       <= '0;
            r_ratio_reg   <= NOB'(DEF_RATIO);
            r_ratio_frame <= NOB'(DEF_RATIO);
            r_bit_cnt     <= '0;
        end else begin
            r_state <= w_next_state;
            if (ratio_setting) begin
                r_ratio_reg <= divide_ratio;
            end
            // Frame parameters are frozen in LOAD so mid-frame ratio writes
            // only take effect on the following frame.
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_sel;
                    end
                end
                LOAD: begin
                    r_shreg       <= data_in[int'(r_grant_id)*WORD +: WORD];
                    r_ratio_frame <= w_ratio_eff;
                    r_bit_cnt     <= '0;
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_shreg   <= {r_shreg[WORD-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                    end
                end
                DONE: begin
                    r_last_grant <= r_grant_id;
                end
                default: ;
            endcase
        end
    end

    assign grant_id = r_grant_id;

endmodule

// File: doc/m_tx_scheduler.md
Name: m_tx_scheduler

Overview:
Round-robin scheduler that shares one serial transmit path between NREQ requesters.
- Grants one requester, captures its WORD-bit word and shifts it out MSB-first on data_o at a programmable bit rate.
- The bit rate is derived from clk by an internal divide-by-N tick generator.
- Sits between the MPU's parallel-producing blocks and the single serial output line; it sequences the divider, bit counter and shift datapath.

Parameters:
WORD, 8, data word width in bits
NOB, 4, width of divide_ratio
MUX, 2, width of grant_id; NREQ = 2**MUX requesters
DEF_RATIO, 4, clocks per bit after reset

Ports:
clk  in  1  system clock, 16 MHz nominal
reset  in  1  synchronous, active-high reset
ratio_setting  in  1  when 1, divide_ratio is loaded into the ratio register on the next edge
divide_ratio  in  NOB  clocks per serial bit; 0 is treated as 1
req  in  NREQ  per-requester request, level; held until matching ack
data_in  in  NREQ*WORD  requester r's word occupies bits [r*WORD +: WORD]
ack  out  NREQ  one-hot, 1-cycle pulse: word captured
grant_id  out  MUX  index of the current or last granted requester
busy  out  1  high from LOAD through DONE
data_o  out  1  serial data, MSB first
bit_valid  out  1  high while data_o carries frame bits (SHIFT state)
done  out  1  1-cycle pulse at end of frame

Behaviour:
Clock and reset:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; ack=0; grant_id=0; busy=0; data_o=0; bit_valid=0; done=0; ratio_reg=DEF_RATIO; last_grant=NREQ-1 (so requester 0 wins first).
- Reset asserted mid-frame aborts the frame on that edge. No done and no ack are produced, and the word is lost.

Ratio register:
- Updated on any edge where ratio_setting=1, including during a frame.
- The value in use for a frame is ratio_frame, copied from ratio_reg in LOAD. A change therefore never alters a frame already in progress.
- Effective ratio is max(divide_ratio,1).

State machine (IDLE, LOAD, SHIFT, DONE):
- IDLE: if |req, select the first set bit scanning from (last_grant+1) mod NREQ upward with wrap. Register grant_id, go to LOAD. Otherwise stay.
- LOAD (exactly 1 cycle):
  - ack[grant_id]=1, decoded from registered state; there is no combinational path from req to ack.
  - On the exiting edge: shreg <= data_in word for grant_id; ratio_frame <= eff(ratio_reg); tick_cnt <= 0; bit_cnt <= 0. Go to SHIFT.
- SHIFT:
  - data_o = shreg[WORD-1]; bit_valid=1.
  - tick_cnt counts 0..ratio_frame-1. When it reaches ratio_frame-1 (a tick): shreg shifts left by 1, tick_cnt wraps to 0, bit_cnt increments.
  - On the tick where bit_cnt=WORD-1, go to DONE.
  - Each bit is held exactly ratio_frame clocks.
- DONE (1 cycle): done=1; data_o=0; last_grant <= grant_id. Go to IDLE.

Latency and timing:
- req seen in IDLE at edge k gives LOAD in cycle k+1 and the first bit in cycle k+2.
- Frame length is 1 + WORD*ratio_frame + 1 cycles.
- At least one IDLE cycle separates consecutive frames.

Requester protocol:
- A requester keeps req and data_in stable until it sees ack.
- Dropping req while in LOAD is a protocol violation; the word is still captured and sent.
- req changes during SHIFT/DONE affect only the next arbitration.
- Simultaneous requests are resolved by the round-robin rule above. No requester waits more than NREQ-1 frames.

Outputs:
- grant_id holds its value outside frames.
- data_o=0 and bit_valid=0 whenever state is not SHIFT.

Decomposition:
- Shared package m_mpu_pkg: state encoding constants (IDLE=0, LOAD=1, SHIFT=2, DONE=3), default WORD/NOB/MUX values, DEF_RATIO.
- One sub-module, m_tick_gen:
  - Inputs: clk, reset, clear, ratio.
  - Output: tick, a 1-cycle pulse every ratio clocks while not cleared.
  - Held in clear outside SHIFT.
- Arbiter, bit counter and shift register stay in m_tx_scheduler.

Test Plan:
1. Reset, then req=4'b0001, data word0=8'hA5, ratio 4 -> ack[0] 1 cycle; data_o sequence 1,0,1,0,0,1,0,1, each bit 4 clocks; bit_valid 32 cycles; done 1 cycle later; total 34 cycles from LOAD through DONE.
2. req=4'b1111 held, with each requester re-asserting after its ack -> grant order 0,1,2,3,0; each ack one-hot; never two acks in one frame.
3. ratio_setting=1, divide_ratio=2 during a frame -> current frame keeps 4 clocks per bit; next frame uses 2 clocks per bit (18 cycles LOAD through DONE); divide_ratio=0 -> 1 clock per bit.
4. reset asserted in the 3rd bit of a frame -> next edge gives state IDLE, all outputs 0, no done; after reset release with req=4'b0100 -> grant_id=2 (priority restarts at 0, first set bit scanning upward).
5. req[1] only, word 8'hFF then 8'h00 back-to-back -> exactly one IDLE cycle between done and the next ack; data_o=0 during IDLE, LOAD and DONE.
6. No request for 100 cycles -> busy, ack, done and bit_valid stay 0; grant_id unchanged.
